// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address, and
// fills the IF/ID register. JALs are pre-decoded so they redirect fetch with no bubble.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 128,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        if_pred_jal,
  output logic        fetch_fault,
  output logic [31:0] fault_pc
);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    FAULT  = 2'd2
  } state_t;

  localparam logic [6:0] OPC_JAL = 7'b1101111;

  state_t      state;
  logic [31:0] pc;
  logic        is_jal;
  logic [31:0] jal_offset;
  logic [31:0] next_pc;
  logic        pc_bad;
  logic        target_bad;

  assign imem_addr = pc;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    is_jal     = 1'b0;
    jal_offset = 32'd4;
    is_jal     = (imem_data[6:0] == OPC_JAL);
    if (is_jal) begin
      // J-type immediate: {imm[20], imm[10:1], imm[11], imm[19:12]} with implicit bit 0.
      jal_offset = {{11{imem_data[31]}}, imem_data[31], imem_data[19:12],
                    imem_data[20], imem_data[30:21], 1'b0};
    end
    next_pc    = pc + jal_offset;
    pc_bad     = (pc[1:0] != 2'b00) || (pc >= IMEM_DEPTH);
    target_bad = (redirect_target[1:0] != 2'b00) || (redirect_target >= IMEM_DEPTH);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WARMUP;
      pc          <= RESET_PC;
      if_pc       <= 32'd0;
      if_instr    <= NOP_WORD;
      if_valid    <= 1'b0;
      if_pred_jal <= 1'b0;
      fetch_fault <= 1'b0;
      fault_pc    <= 32'd0;
    end else begin
      case (state)
        WARMUP: begin
          // Give the instruction memory one clock to present valid data.
          state <= RUN;
        end

        RUN: begin
          if (redirect_valid) begin
            if_valid    <= 1'b0;
            if_instr    <= NOP_WORD;
            if_pred_jal <= 1'b0;
            if (target_bad) begin
              state       <= FAULT;
              fetch_fault <= 1'b1;
              fault_pc    <= redirect_target;
            end else begin
              pc <= redirect_target;
            end
          end else if (!stall) begin
            if (pc_bad) begin
              // Out-of-range next PCs from the previous capture land here, one cycle later.
              state       <= FAULT;
              fetch_fault <= 1'b1;
              fault_pc    <= pc;
              if_valid    <= 1'b0;
              if_instr    <= NOP_WORD;
              if_pred_jal <= 1'b0;
            end else begin
              if_pc       <= pc;
              if_instr    <= imem_data;
              if_valid    <= 1'b1;
              if_pred_jal <= is_jal;
              pc          <= next_pc;
            end
          end
        end

        FAULT: begin
          // Terminal until reset; redirect and stall have no effect.
          if_valid    <= 1'b0;
          if_instr    <= NOP_WORD;
          if_pred_jal <= 1'b0;
        end

        default: state <= FAULT;
      endcase
    end
  end

endmodule
